// File: rtl/cam_bist_ctrl.sv
`default_nettype none
// ============================================================================
// cam_bist_ctrl : write/search self-test initiator and response checker for the vlsu CAM
// Revision      : 1.0
// ============================================================================
module cam_bist_ctrl #(
   parameter int WIDTH      = 50,
   parameter int DEPTH      = 32,
   parameter int READ       = 3,
   parameter int ADDRESS    = $clog2(DEPTH),
   parameter int SEARCH_LAT = 1,
   localparam int PW        = (READ > 1) ? $clog2(READ) : 1
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic                      start_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      pass_o,
   output logic [7:0]                err_count_o,
   output logic [PW-1:0]             fail_port_o,
   output logic [ADDRESS-1:0]        fail_addr_o,
   output logic                      write_o,
   output logic [ADDRESS-1:0]        write_addr_o,
   output logic [WIDTH-1:0]          write_data_o,
   output logic [READ-1:0]           read_o,
   output logic [READ*WIDTH-1:0]     read_data_o,
   input  logic [READ-1:0]           match_i,
   input  logic [READ*ADDRESS-1:0]   match_addr_i
);

   localparam int CNT_MAX = (DEPTH + 2 > SEARCH_LAT) ? DEPTH + 2 : SEARCH_LAT;
   localparam int CW      = $clog2(CNT_MAX);
   localparam int KW      = CW + 1;
   localparam logic [CW-1:0]      C_WR_LAST   = CW'(DEPTH - 1);
   localparam logic [CW-1:0]      C_SR_LAST   = CW'(DEPTH + 1);
   localparam logic [CW-1:0]      C_DR_LAST   = CW'(SEARCH_LAT - 1);
   localparam logic [CW-1:0]      C_DEPTH     = CW'(DEPTH);
   localparam logic [PW-1:0]      C_PORT_LAST = PW'(READ - 1);
   localparam logic [ADDRESS-1:0] C_ADDR_LAST = ADDRESS'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WRITE  = 3'd1,
      S_GAP    = 3'd2,
      S_SEARCH = 3'd3,
      S_DRAIN  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [PW-1:0]             port_q, port_d;

   logic                      write_q, write_d;
   logic [ADDRESS-1:0]        waddr_q, waddr_d;
   logic [WIDTH-1:0]          wdata_q, wdata_d;
   logic [READ-1:0]           read_q, read_d;
   logic [READ*WIDTH-1:0]     rdata_q, rdata_d;
   logic                      busy_q, busy_d;

   logic                      iss_valid_q, iss_valid_d;
   logic [PW-1:0]             iss_port_q, iss_port_d;
   logic                      iss_hit_q, iss_hit_d;
   logic [ADDRESS-1:0]        iss_addr_q, iss_addr_d;

   logic [SEARCH_LAT-1:0]              pv_q, pv_d;
   logic [SEARCH_LAT-1:0][PW-1:0]      pp_q, pp_d;
   logic [SEARCH_LAT-1:0]              ph_q, ph_d;
   logic [SEARCH_LAT-1:0][ADDRESS-1:0] pa_q, pa_d;

   logic [7:0]                err_q, err_d;
   logic [PW-1:0]             fport_q, fport_d;
   logic [ADDRESS-1:0]        faddr_q, faddr_d;
   logic                      pass_q, pass_d;
   logic                      done_q, done_d;

   logic [KW-1:0]             key;
   logic [CW-1:0]             miss_idx;
   logic [PW-1:0]             t_port;
   logic                      t_err;
   logic                      accept;

   assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      port_d  = port_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_WRITE;
               cnt_d   = '0;
               port_d  = '0;
            end
         end
         S_WRITE: begin
            if (cnt_q == C_WR_LAST) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            state_d = S_SEARCH;
            cnt_d   = '0;
            port_d  = '0;
         end
         S_SEARCH: begin
            if (cnt_q == C_SR_LAST) begin
               cnt_d = '0;
               if (port_q == C_PORT_LAST) begin
                  state_d = S_DRAIN;
               end else begin
                  port_d = port_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == C_DR_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every port leaves a flop.
   always_comb begin
      write_d     = 1'b0;
      waddr_d     = '0;
      wdata_d     = '0;
      read_d      = '0;
      rdata_d     = '0;
      key         = '0;
      miss_idx    = '0;
      iss_valid_d = 1'b0;
      iss_port_d  = '0;
      iss_hit_d   = 1'b0;
      iss_addr_d  = '0;
      busy_d      = (state_d == S_WRITE) || (state_d == S_GAP) ||
                    (state_d == S_SEARCH) || (state_d == S_DRAIN);

      if (state_d == S_WRITE) begin
         write_d = 1'b1;
         waddr_d = cnt_d[ADDRESS-1:0];
         wdata_d = WIDTH'({1'b0, cnt_d} + KW'(1));
      end

      if (state_d == S_SEARCH) begin
         if (cnt_d < C_DEPTH) begin
            key        = {1'b0, C_DEPTH} - {1'b0, cnt_d};
            iss_hit_d  = 1'b1;
            iss_addr_d = C_ADDR_LAST - cnt_d[ADDRESS-1:0];
         end else begin
            key        = {1'b0, cnt_d} + KW'(1);
            miss_idx   = cnt_d - C_DEPTH;
            iss_addr_d = miss_idx[ADDRESS-1:0];
         end
         read_d[port_d]                   = 1'b1;
         rdata_d[port_d*WIDTH +: WIDTH]   = WIDTH'(key);
         iss_valid_d                      = 1'b1;
         iss_port_d                       = port_d;
      end
   end

   always_comb begin
      pv_d[0] = iss_valid_q;
      pp_d[0] = iss_port_q;
      ph_d[0] = iss_hit_q;
      pa_d[0] = iss_addr_q;
      for (int i = 1; i < SEARCH_LAT; i++) begin
         pv_d[i] = pv_q[i-1];
         pp_d[i] = pp_q[i-1];
         ph_d[i] = ph_q[i-1];
         pa_d[i] = pa_q[i-1];
      end

      t_port = pp_q[SEARCH_LAT-1];
      t_err  = 1'b0;
      if (pv_q[SEARCH_LAT-1]) begin
         if (ph_q[SEARCH_LAT-1]) begin
            t_err = !match_i[t_port] ||
                    (match_addr_i[t_port*ADDRESS +: ADDRESS] != pa_q[SEARCH_LAT-1]);
         end else begin
            t_err = match_i[t_port];
         end
      end

      err_d   = err_q;
      fport_d = fport_q;
      faddr_d = faddr_q;
      pass_d  = pass_q;
      done_d  = done_q;
      if (accept) begin
         err_d   = '0;
         fport_d = '0;
         faddr_d = '0;
         pass_d  = 1'b0;
         done_d  = 1'b0;
      end else begin
         if (t_err) begin
            if (err_q == 8'd0) begin
               fport_d = t_port;
               faddr_d = pa_q[SEARCH_LAT-1];
            end
            if (err_q != 8'hFF) begin
               err_d = err_q + 8'd1;
            end
         end
         // The final check lands on the same edge that enters DONE.
         if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            done_d = 1'b1;
            pass_d = (err_d == 8'd0);
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         port_q      <= '0;
         write_q     <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         read_q      <= '0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
         iss_valid_q <= 1'b0;
         iss_port_q  <= '0;
         iss_hit_q   <= 1'b0;
         iss_addr_q  <= '0;
         pv_q        <= '0;
         pp_q        <= '0;
         ph_q        <= '0;
         pa_q        <= '0;
         err_q       <= '0;
         fport_q     <= '0;
         faddr_q     <= '0;
         pass_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         port_q      <= port_d;
         write_q     <= write_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         read_q      <= read_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
         iss_valid_q <= iss_valid_d;
         iss_port_q  <= iss_port_d;
         iss_hit_q   <= iss_hit_d;
         iss_addr_q  <= iss_addr_d;
         pv_q        <= pv_d;
         pp_q        <= pp_d;
         ph_q        <= ph_d;
         pa_q        <= pa_d;
         err_q       <= err_d;
         fport_q     <= fport_d;
         faddr_q     <= faddr_d;
         pass_q      <= pass_d;
         done_q      <= done_d;
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign pass_o       = pass_q;
   assign err_count_o  = err_q;
   assign fail_port_o  = fport_q;
   assign fail_addr_o  = faddr_q;
   assign write_o      = write_q;
   assign write_addr_o = waddr_q;
   assign write_data_o = wdata_q;
   assign read_o       = read_q;
   assign read_data_o  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_bist_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cam_bist_ctrl : drives cam_bist_ctrl against a behavioural CAM with injectable faults
// Revision         : 1.0
// ============================================================================
module tb_cam_bist_ctrl;

   localparam int WIDTH      = 50;
   localparam int DEPTH      = 32;
   localparam int READ       = 3;
   localparam int ADDRESS    = 5;
   localparam int SEARCH_LAT = 1;
   localparam int PW         = 2;
   localparam int LATENCY    = DEPTH + 1 + READ * (DEPTH + 2) + SEARCH_LAT;

   logic                    clk = 1'b0;
   logic                    arst_n;
   logic                    start_i;
   logic                    busy_o, done_o, pass_o;
   logic [7:0]              err_count_o;
   logic [PW-1:0]           fail_port_o;
   logic [ADDRESS-1:0]      fail_addr_o;
   logic                    write_o;
   logic [ADDRESS-1:0]      write_addr_o;
   logic [WIDTH-1:0]        write_data_o;
   logic [READ-1:0]         read_o;
   logic [READ*WIDTH-1:0]   read_data_o;
   logic [READ-1:0]         cam_match;
   logic [READ*ADDRESS-1:0] cam_addr;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cam_bist_ctrl #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .READ(READ), .ADDRESS(ADDRESS), .SEARCH_LAT(SEARCH_LAT)
   ) dut (
      .clk(clk), .arst_n(arst_n), .start_i(start_i),
      .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
      .err_count_o(err_count_o), .fail_port_o(fail_port_o), .fail_addr_o(fail_addr_o),
      .write_o(write_o), .write_addr_o(write_addr_o), .write_data_o(write_data_o),
      .read_o(read_o), .read_data_o(read_data_o),
      .match_i(cam_match), .match_addr_i(cam_addr)
   );

   // Behavioural CAM with fault knobs: dropped writes, wrong hit address, phantom miss hits.
   logic [WIDTH-1:0]   mem_d    [DEPTH];
   logic               mem_v    [DEPTH];
   logic               clr;
   logic               drop     [DEPTH];
   logic [ADDRESS-1:0] ret_addr [DEPTH];
   logic               phantom  [READ][2];

   function automatic logic [ADDRESS:0] cam_search(input logic [WIDTH-1:0] key, input int p);
      logic               hit = 1'b0;
      logic [ADDRESS-1:0] a   = ADDRESS'($urandom);
      for (int j = 0; j < DEPTH; j++)
         if (mem_v[j] && mem_d[j] == key) begin
            hit = 1'b1;
            a   = ret_addr[j];
         end
      for (int k = 0; k < 2; k++)
         if (phantom[p][k] && key == WIDTH'(DEPTH + 1 + k)) hit = 1'b1;
      return {hit, a};
   endfunction

   always @(posedge clk) begin
      for (int p = 0; p < READ; p++) begin
         if (read_o[p])
            {cam_match[p], cam_addr[p*ADDRESS +: ADDRESS]} <= cam_search(read_data_o[p*WIDTH +: WIDTH], p);
         else begin
            cam_match[p]                   <= 1'($urandom);
            cam_addr[p*ADDRESS +: ADDRESS] <= ADDRESS'($urandom);
         end
      end
      for (int j = 0; j < DEPTH; j++) begin
         if (clr) mem_v[j] <= 1'b0;
         else if (write_o && write_addr_o == ADDRESS'(j) && !drop[j]) begin
            mem_v[j] <= 1'b1;
            mem_d[j] <= write_data_o;
         end
      end
   end

   // Expected results from walking the test sequence against the fault knobs.
   function automatic void ref_model(output int cnt, output int fp, output int fa);
      bit bad;
      cnt = 0; fp = 0; fa = 0;
      for (int p = 0; p < READ; p++) begin
         for (int j = DEPTH - 1; j >= 0; j--) begin
            bad = drop[j] || (ret_addr[j] != ADDRESS'(j));
            if (bad) begin
               if (cnt == 0) begin fp = p; fa = j; end
               if (cnt < 255) cnt++;
            end
         end
         for (int k = 0; k < 2; k++) begin
            if (phantom[p][k]) begin
               if (cnt == 0) begin fp = p; fa = k; end
               if (cnt < 255) cnt++;
            end
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_ideal();
      for (int j = 0; j < DEPTH; j++) begin
         drop[j]     = 1'b0;
         ret_addr[j] = ADDRESS'(j);
      end
      for (int p = 0; p < READ; p++) begin
         phantom[p][0] = 1'b0;
         phantom[p][1] = 1'b0;
      end
   endtask

   task automatic set_random();
      for (int j = 0; j < DEPTH; j++) begin
         drop[j]     = ($urandom_range(0, 9) == 0);
         ret_addr[j] = ($urandom_range(0, 7) == 0) ? ADDRESS'($urandom) : ADDRESS'(j);
      end
      for (int p = 0; p < READ; p++) begin
         phantom[p][0] = ($urandom_range(0, 3) == 0);
         phantom[p][1] = ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic run_test(input string tag, input bit poke_start, input int abort_at);
      int n;
      int e_cnt, e_fp, e_fa;
      ref_model(e_cnt, e_fp, e_fa);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      start_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      chk({tag, ".busy_start"}, 64'(busy_o), 64'd1);
      chk({tag, ".done_clr"}, 64'(done_o), 64'd0);
      chk({tag, ".wr0"}, {write_o, 58'(write_addr_o), 5'd0}, {1'b1, 63'd0});
      chk({tag, ".wdata0"}, 64'(write_data_o), 64'd1);
      n = 0;
      while (!done_o && n < 1000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         start_i = poke_start && (n == 60);
         if (abort_at != 0 && n == abort_at) begin
            arst_n = 1'b0;
            #1;
            chk({tag, ".rst_busy"}, 64'(busy_o), 64'd0);
            chk({tag, ".rst_read"}, 64'(read_o), 64'd0);
            chk({tag, ".rst_key"}, 64'(read_data_o != '0), 64'd0);
            chk({tag, ".rst_res"}, {56'(err_count_o), done_o, pass_o, 6'd0}, 64'd0);
            @(negedge clk);
            arst_n = 1'b1;
            return;
         end
      end
      start_i = 1'b0;
      chk({tag, ".latency"}, 64'(n), 64'(LATENCY));
      chk({tag, ".done"}, 64'(done_o), 64'd1);
      chk({tag, ".busy_end"}, 64'(busy_o), 64'd0);
      chk({tag, ".pass"}, 64'(pass_o), 64'(e_cnt == 0));
      chk({tag, ".err_count"}, 64'(err_count_o), 64'(e_cnt));
      chk({tag, ".fail_port"}, 64'(fail_port_o), 64'(e_fp));
      chk({tag, ".fail_addr"}, 64'(fail_addr_o), 64'(e_fa));
   endtask

   initial begin
      arst_n  = 1'b0;
      start_i = 1'b0;
      clr     = 1'b0;
      set_ideal();
      repeat (3) @(negedge clk);
      chk("reset.outs", {busy_o, done_o, pass_o, write_o, 60'(err_count_o)}, 64'd0);
      chk("reset.read", 64'(read_o), 64'd0);
      arst_n = 1'b1;
      @(negedge clk);

      run_test("ideal", 1'b0, 0);

      drop[5] = 1'b1;
      run_test("drop5", 1'b0, 0);
      set_ideal();

      for (int j = 0; j < DEPTH; j++) ret_addr[j] = '0;
      run_test("addr0", 1'b0, 0);
      set_ideal();

      phantom[2][0] = 1'b1;
      run_test("phantom_p2", 1'b0, 0);
      set_ideal();

      for (int j = 0; j < DEPTH; j++) drop[j] = 1'b1;
      for (int p = 0; p < READ; p++) begin
         phantom[p][0] = 1'b1;
         phantom[p][1] = 1'b1;
      end
      run_test("all_bad", 1'b1, 0);
      set_ideal();

      run_test("abort", 1'b0, 80);
      run_test("restart", 1'b0, 0);

      for (int r = 0; r < 3; r++) begin
         set_random();
         run_test($sformatf("rand%0d", r), 1'b0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
